// File: rtl/scie_pipelined_simd.sv
// scie_pipelined_simd: custom-3 SIMD activation/compare unit (RELU, CLAMP,
// MAX, MIN) behind a STAGES-deep valid/ready register pipeline.
// Optional feature macro: SCIE_CLIP_STATS_EN -- when defined, a saturating
// counter of clipped lanes is built; otherwise io_clip_count is tied to 0.

// Per-lane datapath: one signed W-bit lane, pure combinational.
module scie_lane #(
  parameter int W = 32
) (
  input  logic [1:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);
  logic [W-1:0] relu;

  // Select the lane result; CLAMP with a negative upper bound collapses to 0.
  always_comb begin
    y_o  = '0;
    relu = a_i[W-1] ? '0 : a_i;
    case (op_i)
      2'd0:    y_o = relu;
      2'd1:    y_o = b_i[W-1] ? '0 : (($signed(relu) > $signed(b_i)) ? b_i : relu);
      2'd2:    y_o = ($signed(a_i) > $signed(b_i)) ? a_i : b_i;
      default: y_o = ($signed(a_i) < $signed(b_i)) ? a_i : b_i;
    endcase
  end
endmodule

module scie_pipelined_simd #(
  parameter int XLEN   = 32,
  parameter int LANES  = 1,
  parameter int STAGES = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_in_valid,
  output logic            io_in_ready,
  input  logic [31:0]     io_insn,
  input  logic [XLEN-1:0] io_rs1,
  input  logic [XLEN-1:0] io_rs2,
  output logic            io_out_valid,
  input  logic            io_out_ready,
  output logic [XLEN-1:0] io_rd,
  output logic            io_illegal,
  output logic [31:0]     io_clip_count
);
  localparam int W = XLEN / LANES;

  typedef struct packed {
    logic [XLEN-1:0] rd;
    logic            illegal;
`ifdef SCIE_CLIP_STATS_EN
    logic [2:0]      clips;
`endif
  } stg_t;

  logic [LANES-1:0][W-1:0] rs1_l, rs2_l, y_l;
  logic [2:0]              op;
  logic                    legal;
  logic                    acc;
  stg_t                    stg_d;

  stg_t [STAGES:1]         stg_q;
  stg_t [STAGES:1]         stg_in;
  logic [STAGES:1]         vld_pipe_q;
  logic [STAGES:1]         vld_in;
  logic [STAGES:1]         adv;

  // Only opcode and funct3 carry meaning; the rest of the word is ignored.
  logic unused_insn;
  assign unused_insn = ^{io_insn[31:15], io_insn[11:7]};

  assign rs1_l = io_rs1;
  assign rs2_l = io_rs2;
  assign op    = io_insn[14:12];
  assign legal = (io_insn[6:0] == 7'h7B) && !op[2];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    scie_lane #(.W(W)) u_lane (
      .op_i (op[1:0]),
      .a_i  (rs1_l[i]),
      .b_i  (rs2_l[i]),
      .y_o  (y_l[i])
    );
  end

  // Stage-1 payload: lane results, zeroed for unsupported instructions.
  always_comb begin
    stg_d         = '0;
    stg_d.rd      = legal ? y_l : '0;
    stg_d.illegal = !legal;
`ifdef SCIE_CLIP_STATS_EN
    // A lane clips when RELU/CLAMP changed its rs1 value.
    for (int i = 0; i < LANES; i++)
      stg_d.clips = stg_d.clips + 3'((legal && !op[1] && (y_l[i] != rs1_l[i])) ? 1 : 0);
`endif
  end

  // Backpressure chain: a stage moves when empty or when its successor moves.
  always_comb begin
    adv         = '0;
    adv[STAGES] = !vld_pipe_q[STAGES] || io_out_ready;
    for (int s = STAGES - 1; s >= 1; s--)
      adv[s] = !vld_pipe_q[s] || adv[s+1];
  end

  assign io_in_ready = reset && adv[1];
  assign acc         = io_in_valid && io_in_ready;

  // Stage input muxing: stage 1 takes the new request, others their predecessor.
  always_comb begin
    vld_in    = '0;
    stg_in    = '0;
    vld_in[1] = acc;
    stg_in[1] = stg_d;
    for (int s = 2; s <= STAGES; s++) begin
      vld_in[s] = vld_pipe_q[s-1];
      stg_in[s] = stg_q[s-1];
    end
  end

  // Pipeline registers; reset discards everything in flight.
  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_pipe_q <= '0;
      stg_q      <= '0;
    end else begin
      for (int s = 1; s <= STAGES; s++) begin
        if (adv[s]) begin
          vld_pipe_q[s] <= vld_in[s];
          stg_q[s]      <= stg_in[s];
        end
      end
    end
  end

  assign io_out_valid = vld_pipe_q[STAGES];
  assign io_rd        = vld_pipe_q[STAGES] ? stg_q[STAGES].rd : '0;
  assign io_illegal   = vld_pipe_q[STAGES] && stg_q[STAGES].illegal;

`ifdef SCIE_CLIP_STATS_EN
  logic [31:0] clip_cnt_q, clip_cnt_d;
  logic [32:0] clip_sum;

  // Saturating accumulate of clipped lanes at each output handshake.
  always_comb begin
    clip_sum   = {1'b0, clip_cnt_q} + {30'd0, stg_q[STAGES].clips};
    clip_cnt_d = clip_cnt_q;
    if (io_out_valid && io_out_ready)
      clip_cnt_d = clip_sum[32] ? '1 : clip_sum[31:0];
  end

  // Clip counter register.
  always_ff @(posedge clock) begin
    if (!reset) clip_cnt_q <= '0;
    else        clip_cnt_q <= clip_cnt_d;
  end

  assign io_clip_count = clip_cnt_q;
`else
  assign io_clip_count = '0;
`endif
endmodule
